// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg -- shared definitions for the pipelined control unit.
//
// Contents:
//   - opcode localparams for every decoded instruction class
//   - alu_op_e      : 4-bit ALU operation code (zero-extended at the top)
//   - result_src_e  : writeback result selector
//   - imm_src_e     : immediate format selector
//   - idex_ctrl_t / exmem_ctrl_t / memwb_ctrl_t : per-stage control bundles
//   - branch_taken(): branch condition evaluation from funct3 and ALU flags
//
// The optional jump opcodes are only decoded when the JUMP_EN macro is
// defined; their opcode values live here unconditionally.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Native width of the ALU code; the top zero-extends to ALUCTRL_W.
    localparam int ALU_CODE_W = 4;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011
    } imm_src_e;

    // Everything the EX stage needs; funct3 rides along so the branch
    // condition can be evaluated once the ALU flags are available.
    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        alu_op_e     alu_ctrl;
        logic [2:0]  funct3;
    } idex_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
    } exmem_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } memwb_ctrl_t;

    // A bubble is simply every control bit cleared.
    localparam idex_ctrl_t  IDEX_BUBBLE  = '0;
    localparam exmem_ctrl_t EXMEM_BUBBLE = '0;
    localparam memwb_ctrl_t MEMWB_BUBBLE = '0;

    // funct3 010/011 are not defined branch conditions and never take.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_decoder -- purely combinational Decode-stage instruction decoder.
//
// Ports:
//   op      in  7  opcode field
//   funct3  in  3  funct3 field
//   funct7  in  7  funct7 field
//   ctrl    out    idex_ctrl_t bundle for the instruction (bubble if illegal)
//   imm_src out 3  immediate format (IMM_I / 000 for illegal opcodes)
//   illegal out 1  opcode not supported in this build
//
// Build option: JUMP_EN -- when defined, JAL and JALR are decoded; otherwise
// they fall into the illegal class and RES_PC4 is never produced.
// ---------------------------------------------------------------------------
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output idex_ctrl_t ctrl,
    output imm_src_e   imm_src,
    output logic       illegal
);

    // Shared ALU decode for R-type and I-ALU. sub_ok is only true for
    // register-register ops (op[5]=1), so ADDI with imm[10]=1 stays ADD.
    // SRA/SRAI are distinguished by funct7[5] in both formats.
    function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                           input logic       sub_ok,
                                           input logic       alt);
        alu_op_e res;
        case (f3)
            3'b000:  res = sub_ok ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

    always_comb begin
        ctrl    = IDEX_BUBBLE;
        imm_src = IMM_I;
        illegal = 1'b0;

        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_decode(funct3, op[5] & funct7[5], funct7[5]);
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_decode(funct3, op[5] & funct7[5], funct7[5]);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src    = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_BRANCH: begin
                // The EX flags come from the datapath comparator, so the
                // ALU code is left at ADD (it computes nothing we consume).
                ctrl.branch = 1'b1;
                ctrl.funct3 = funct3;
                imm_src     = IMM_B;
            end
`ifdef JUMP_EN
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
            end
`endif
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit -- decodes in Decode and carries the controls
// through the ID/EX, EX/MEM and MEM/WB registers; resolves branches/jumps
// in EX and handles stall/flush bubble insertion.
//
// Parameters:
//   ALUCTRL_W   width of ALUControlE (>= 4; codes are zero-extended)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   opD, funct3D, funct7D      Decode-stage instruction fields
//   StallD                     hold Decode: issue a bubble into EX
//   ZeroE, LtE, LtuE           EX-stage comparison flags
//   ImmSrcD, IllegalD          combinational Decode outputs
//   ALUControlE, ALUSrcE       EX controls (1 cycle after Decode)
//   PCSrcE, FlushD             taken branch/jump in EX; FlushD == PCSrcE
//   MemWriteM, RegWriteM       MEM controls (2 cycles after Decode)
//   ResultSrcW, RegWriteW      WB controls (3 cycles after Decode)
//
// Build option: JUMP_EN enables JAL/JALR decode (see ctrl_decoder).
// ---------------------------------------------------------------------------
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic [6:0]           funct7D,
    input  logic                 StallD,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 PCSrcE,
    output logic                 FlushD,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic [1:0]           ResultSrcW,
    output logic                 RegWriteW
);

    if (ALUCTRL_W < ALU_CODE_W) begin : g_width_check
        $error("pipelined_control_unit: ALUCTRL_W must be at least 4");
    end

    idex_ctrl_t  dec_ctrl;
    imm_src_e    dec_imm;
    logic        dec_illegal;

    idex_ctrl_t  idex_reg,  idex_next;
    exmem_ctrl_t exmem_reg, exmem_next;
    memwb_ctrl_t memwb_reg, memwb_next;

    logic        pcsrc_e;

    ctrl_decoder u_decoder (
        .op      (opD),
        .funct3  (funct3D),
        .funct7  (funct7D),
        .ctrl    (dec_ctrl),
        .imm_src (dec_imm),
        .illegal (dec_illegal)
    );

    // Bubbles carry branch = jump = 0, so a squashed slot can never redirect.
    always_comb begin
        pcsrc_e = idex_reg.jump |
                  (idex_reg.branch & branch_taken(idex_reg.funct3, ZeroE, LtE, LtuE));
    end

    always_comb begin
        // A taken branch/jump squashes the wrong-path instruction in Decode;
        // a stall holds it in Decode. Either way EX receives a bubble.
        // Illegal opcodes already decode to a bubble.
        if (StallD || pcsrc_e) begin
            idex_next = IDEX_BUBBLE;
        end else begin
            idex_next = dec_ctrl;
        end

        // Later stages advance every cycle regardless of stall.
        exmem_next            = EXMEM_BUBBLE;
        exmem_next.reg_write  = idex_reg.reg_write;
        exmem_next.result_src = idex_reg.result_src;
        exmem_next.mem_write  = idex_reg.mem_write;

        memwb_next            = MEMWB_BUBBLE;
        memwb_next.reg_write  = exmem_reg.reg_write;
        memwb_next.result_src = exmem_reg.result_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_reg  <= IDEX_BUBBLE;
            exmem_reg <= EXMEM_BUBBLE;
            memwb_reg <= MEMWB_BUBBLE;
        end else begin
            idex_reg  <= idex_next;
            exmem_reg <= exmem_next;
            memwb_reg <= memwb_next;
        end
    end

    assign ImmSrcD     = dec_imm;
    assign IllegalD    = dec_illegal;
    assign ALUControlE = ALUCTRL_W'(idex_reg.alu_ctrl);
    assign ALUSrcE     = idex_reg.alu_src;
    assign PCSrcE      = pcsrc_e;
    assign FlushD      = pcsrc_e;
    assign MemWriteM   = exmem_reg.mem_write;
    assign RegWriteM   = exmem_reg.reg_write;
    assign ResultSrcW  = memwb_reg.result_src;
    assign RegWriteW   = memwb_reg.reg_write;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit -- directed and randomized stimulus against a
// cycle-indexed reference: each cycle records what instruction (or bubble)
// was issued into EX; the E/M/W outputs at cycle c are then the records
// issued at c-1, c-2 and c-3. Honours JUMP_EN like the design.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [6:0]   opD = '0;
    logic [2:0]   funct3D = '0;
    logic [6:0]   funct7D = '0;
    logic         StallD = 1'b0;
    logic         ZeroE = 1'b0;
    logic         LtE = 1'b0;
    logic         LtuE = 1'b0;
    logic [2:0]   ImmSrcD;
    logic         IllegalD;
    logic [W-1:0] ALUControlE;
    logic         ALUSrcE;
    logic         PCSrcE;
    logic         FlushD;
    logic         MemWriteM;
    logic         RegWriteM;
    logic [1:0]   ResultSrcW;
    logic         RegWriteW;

    pipelined_control_unit #(.ALUCTRL_W(W)) dut (
        .clk(clk), .rst(rst), .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
        .StallD(StallD), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE), .FlushD(FlushD),
        .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       as;
        int       alu;
        bit       br;
        bit       jp;
        bit [2:0] f3;
    } rec_t;

    localparam bit [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011,
                         ST_OP = 7'b0100011, BR_OP = 7'b1100011,
                         JAL_OP = 7'b1101111, JALR_OP = 7'b1100111;

    rec_t hist [0:1023];
    rec_t bub;
    int   cyc;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference decode written from the instruction-set rules.
    task automatic ref_decode(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                              output rec_t r, output bit ill, output int imm);
        int base [8];
        base = '{0, 7, 5, 6, 4, 8, 3, 2};   // ADD SLL SLT SLTU XOR SRL OR AND
        r = bub; ill = 1'b0; imm = 0;
        if (op == R_OP || op == I_OP) begin
            r.rw = 1'b1;
            r.as = (op == I_OP);
            r.alu = base[f3];
            if (f3 == 3'd0 && op == R_OP && f7[5]) r.alu = 1;
            if (f3 == 3'd5 && f7[5]) r.alu = 9;
        end else if (op == LD_OP) begin
            r.rw = 1'b1; r.rs = 2'b01; r.as = 1'b1;
        end else if (op == ST_OP) begin
            r.mw = 1'b1; r.as = 1'b1; imm = 1;
        end else if (op == BR_OP) begin
            r.br = 1'b1; r.f3 = f3; imm = 2;
`ifdef JUMP_EN
        end else if (op == JAL_OP) begin
            r.rw = 1'b1; r.rs = 2'b10; r.jp = 1'b1; imm = 3;
        end else if (op == JALR_OP) begin
            r.rw = 1'b1; r.rs = 2'b10; r.jp = 1'b1; r.as = 1'b1;
`endif
        end else begin
            ill = 1'b1;
        end
    endtask

    function automatic bit cond(input bit [2:0] f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive, check every output, record what issues.
    task automatic step(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                        input bit stall, input bit z, input bit lt, input bit ltu,
                        input bit r);
        rec_t d, e, m, w;
        bit   ill, tk;
        int   imm;
        @(negedge clk);
        opD = op; funct3D = f3; funct7D = f7; StallD = stall;
        ZeroE = z; LtE = lt; LtuE = ltu; rst = r;
        #1;
        ref_decode(op, f3, f7, d, ill, imm);
        e = hist[cyc-1]; m = hist[cyc-2]; w = hist[cyc-3];
        tk = e.jp || (e.br && cond(e.f3, z, lt, ltu));
        chk("ImmSrcD",     32'(ImmSrcD),     32'(imm));
        chk("IllegalD",    32'(IllegalD),    32'(ill));
        chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
        chk("ALUSrcE",     32'(ALUSrcE),     32'(e.as));
        chk("PCSrcE",      32'(PCSrcE),      32'(tk));
        chk("FlushD",      32'(FlushD),      32'(tk));
        chk("MemWriteM",   32'(MemWriteM),   32'(m.mw));
        chk("RegWriteM",   32'(RegWriteM),   32'(m.rw));
        chk("ResultSrcW",  32'(ResultSrcW),  32'(w.rs));
        chk("RegWriteW",   32'(RegWriteW),   32'(w.rw));
        $display("cyc=%0d op=%b f3=%0d stall=%0b rst=%0b pcsrc=%0b E.alu=%0d M.rw=%0b W.rw=%0b W.rs=%0d",
                 cyc, op, f3, stall, r, PCSrcE, ALUControlE, RegWriteM, RegWriteW, ResultSrcW);
        hist[cyc] = (stall || tk || ill || r) ? bub : d;
        if (r) begin
            hist[cyc-1] = bub;
            hist[cyc-2] = bub;
        end
        cyc++;
    endtask

    task automatic nop(input bit z, input bit lt, input bit ltu);
        step(I_OP, 3'd0, 7'd0, 1'b0, z, lt, ltu, 1'b0);
    endtask

    initial begin
        bit [6:0] ops [9];
        bit [6:0] f7;
        bub = '{default: 0};
        for (int i = 0; i < 1024; i++) hist[i] = bub;
        cyc = 3;
        ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP, 7'b0110111, 7'b0000000};

        // Hold reset for two edges before any comparison.
        repeat (2) @(posedge clk);

        // Reset state, released this cycle.
        step(I_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // R-type SUB, then drain to writeback.
        step(R_OP, 3'd0, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // lw followed by sw.
        step(LD_OP, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(ST_OP, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(0, 0, 0); nop(0, 0, 0);
        // Taken BLT: the instruction behind it is squashed.
        step(BR_OP, 3'd4, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(R_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nop(0, 1, 0); nop(0, 0, 0);
        // Not-taken BGEU with LtuE=1.
        step(BR_OP, 3'd7, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(R_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nop(0, 0, 0);
        // ADD held by a two-cycle stall.
        step(R_OP, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(R_OP, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(R_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(0, 0, 0); nop(0, 0, 0); nop(0, 0, 0);
        // Stall coincident with a taken branch.
        step(BR_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(ST_OP, 3'd0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nop(0, 0, 0);
        // Reset with three instructions in flight.
        step(R_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(ST_OP, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(LD_OP, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(I_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(0, 0, 0); nop(0, 0, 0); nop(0, 0, 0);
        // Shift variants and ADDI with imm[10] set.
        step(R_OP, 3'd5, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(I_OP, 3'd5, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(I_OP, 3'd0, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // JAL: PCSrcE in EX, PC+4 writeback (or illegal without JUMP_EN).
        step(JAL_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(0, 0, 0); nop(0, 0, 0); nop(0, 0, 0); nop(0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       f7 = 7'b0000000;
                1:       f7 = 7'b0100000;
                default: f7 = 7'($urandom);
            endcase
            step(ops[$urandom_range(0, 8)], 3'($urandom), f7,
                 ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 39) == 0));
        end
        nop(0, 0, 0); nop(0, 0, 0); nop(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 4: width of the ALU control code; values below 4 are illegal.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opD / funct3D / funct7D  input  7/3/7  instruction fields in the Decode stage.
REQ-005 StallD  input  1  hazard-unit stall; the instruction in Decode is not issued this cycle.
REQ-006 ZeroE / LtE / LtuE  input  1 each  EX-stage ALU flags: equal, signed less-than, unsigned less-than.
REQ-007 ImmSrcD  output  3  immediate format for the Decode-stage instruction (combinational).
REQ-008 IllegalD  output  1  Decode-stage opcode is unsupported.
REQ-009 ALUControlE  output  ALUCTRL_W; ALUSrcE  output  1  EX-stage controls.
REQ-010 PCSrcE  output  1  taken branch or jump resolved in EX.
REQ-011 FlushD  output  1  squash the Fetch/Decode register.
REQ-012 MemWriteM  output  1; RegWriteM  output  1  Memory-stage controls (RegWriteM also serves forwarding).
REQ-013 ResultSrcW  output  2; RegWriteW  output  1  Writeback-stage controls.

Function
REQ-014 The block SHALL decode combinationally in Decode and register the controls through three stages: ID/EX, EX/MEM and MEM/WB.
REQ-015 Latency SHALL be 1 cycle from Decode to the E outputs, 2 cycles to the M outputs and 3 cycles to the W outputs.
REQ-016 Decoded opcodes SHALL be: R-type 0110011, I-ALU 0010011, load 0000011, store 0100011 and branch 1100011.
REQ-017 ALU codes SHALL be: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, zero-extended to ALUCTRL_W.
REQ-018 SUB SHALL be selected only when opD[5]=1 and funct7D[5]=1 with funct3D=000; SRA SHALL be selected when funct3D=101 and funct7D[5]=1.
REQ-019 ResultSrc SHALL encode 00 = ALU, 01 = memory, 10 = PC+4.
REQ-020 Branch taken condition by funct3: 000 ZeroE; 001 !ZeroE; 100 LtE; 101 !LtE; 110 LtuE; 111 !LtuE; 010/011 never taken.
REQ-021 PCSrcE SHALL be high only in the cycle the branch (or jump) occupies EX; FlushD SHALL equal PCSrcE.
REQ-022 When PCSrcE=1, ID/EX SHALL load a bubble next cycle (all controls 0, including branch/jump flags).
REQ-023 When StallD=1, ID/EX SHALL load a bubble; EX/MEM and MEM/WB SHALL continue advancing.
REQ-024 When StallD and PCSrcE are both 1, the result SHALL be a bubble with FlushD=1.
REQ-025 For an illegal opcode, IllegalD SHALL be 1 and the instruction SHALL be issued as a bubble; ImmSrcD SHALL be 000.
REQ-026 A bubble SHALL never assert RegWrite, MemWrite or PCSrc at any stage.

Reset
REQ-027 While rst=1 at a clock edge, all pipeline registers SHALL load a bubble.
REQ-028 One cycle after reset, all E/M/W outputs SHALL be 0, and PCSrcE and FlushD SHALL be 0.
REQ-029 Reset asserted mid-pipeline SHALL discard every in-flight instruction with no write side effects.

Configuration
REQ-030 Macro JUMP_EN defined: JAL 1101111 and JALR 1100111 SHALL decode as follows.
- RegWrite=1 and ResultSrc=10.
- PCSrcE=1 unconditionally in EX.
- JALR uses ALUSrc=1 with ADD.
REQ-031 JUMP_EN undefined: those opcodes SHALL be illegal, and ResultSrc value 10 SHALL never be produced.

Structure
REQ-032 Package ctrl_pkg SHALL hold:
- the opcode localparams;
- the ALU-code enum;
- the ResultSrc and ImmSrc encodings;
- the packed stage-control struct types.
REQ-033 Decode logic SHALL be one sub-module, ctrl_decoder; the stage registers, flush and stall handling SHALL live in the top module.

Verification
REQ-034 R-type SUB: opD=0110011, funct3D=000, funct7D=0100000 -> next cycle ALUControlE=1, ALUSrcE=0; 3 cycles later RegWriteW=1 and ResultSrcW=00.
REQ-035 Load then store: lw (opD=0000011) followed by sw (opD=0100011) -> lw shows ResultSrcW=01 and RegWriteW=1 at cycle 3; sw shows MemWriteM=1 at cycle 3 and RegWriteW=0 at cycle 4.
REQ-036 Taken BLT: opD=1100011, funct3D=100, then LtE=1 in EX -> PCSrcE=FlushD=1 for exactly 1 cycle; next cycle all E controls are 0.
REQ-037 Not-taken BGEU: funct3D=111 with LtuE=1 -> PCSrcE remains 0 and no bubble is inserted.
REQ-038 Stall and reset: StallD=1 for 2 cycles on an ADD -> two bubbles, with RegWriteW=0 in the corresponding W cycles. rst=1 with 3 instructions in flight -> RegWriteM, RegWriteW and MemWriteM stay 0 thereafter.
REQ-039 JUMP_EN build: opD=1101111 -> PCSrcE=1 in EX and ResultSrcW=10 with RegWriteW=1. Non-JUMP_EN build: the same opcode -> IllegalD=1.
